// File: rtl/dms_sim_ctrl_pkg.sv
// Shared types and constants for the Ibex demo-system simulation controller.
package dms_sim_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam logic [1:0] REG_EXIT    = 2'd0;
  localparam logic [1:0] REG_CONSOLE = 2'd1;
  localparam logic [1:0] REG_CYCLES  = 2'd2;
  localparam logic [1:0] REG_TIMEOUT = 2'd3;

  localparam int unsigned EXIT_CODE_W = 8;

  // Byte-lane merge of a bus write into an existing 32-bit register value.
  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dms_rst_seq.sv
// Reset hold sequencer: counts cycles spent in HOLD and raises go once the
// system reset has been held for ResetHoldCycles cycles.
module dms_rst_seq #(
  parameter int unsigned ResetHoldCycles = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  output logic go
);

  localparam int unsigned CntW = $clog2(ResetHoldCycles + 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(ResetHoldCycles);

  logic [CntW-1:0] hold_cnt;

  assign go = hold && (hold_cnt == HoldLast);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (!hold) begin
      hold_cnt <= '0;
    end else if (!go) begin
      hold_cnt <= hold_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/dms_sim_ctrl.sv
// Simulation/bring-up controller: system reset sequencing, run-cycle counting,
// timeout and exit register. Optional console register: DMS_SIM_CTRL_CONSOLE_EN.
module dms_sim_ctrl
  import dms_sim_ctrl_pkg::*;
#(
  parameter int unsigned ResetHoldCycles = 4,
  parameter int unsigned TimeoutDefault  = 500,
  parameter int unsigned CntWidth        = 32
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_sys_ni,
  input  logic                   device_req_i,
  input  logic                   device_we_i,
  input  logic [3:0]             device_be_i,
  input  logic [31:0]            device_addr_i,
  input  logic [31:0]            device_wdata_i,
  output logic                   device_rvalid_o,
  output logic [31:0]            device_rdata_o,
  output logic                   sys_rst_no,
  output logic                   done_o,
  output logic                   pass_o,
  output logic                   timeout_o,
  output logic [EXIT_CODE_W-1:0] exit_code_o,
  output logic [CntWidth-1:0]    cycle_count_o
`ifdef DMS_SIM_CTRL_CONSOLE_EN
  ,
  output logic [7:0]             console_char_o,
  output logic                   console_valid_o
`endif
);

  state_e                 state_q, state_d;
  logic [CntWidth-1:0]    cycle_q, timeout_q;
  logic [EXIT_CODE_W-1:0] exit_code_q;
  logic                   sys_rst_q, rvalid_q;
  logic [31:0]            rdata_q, read_val, timeout_merged;
  logic [1:0]             reg_idx;
  logic                   go, wr_en, exit_wr, timeout_wr, timeout_hit;
  logic                   unused_addr_bits;

  assign reg_idx          = device_addr_i[3:2];
  assign unused_addr_bits = ^{device_addr_i[31:4], device_addr_i[1:0]};

  assign wr_en       = device_req_i && device_we_i && (state_q == ST_RUN);
  assign exit_wr     = wr_en && (reg_idx == REG_EXIT) && device_be_i[0];
  assign timeout_wr  = wr_en && (reg_idx == REG_TIMEOUT);
  assign timeout_hit = (timeout_q != '0) && (cycle_q == timeout_q);
  assign timeout_merged = apply_be(32'(timeout_q), device_wdata_i, device_be_i);

  dms_rst_seq #(
    .ResetHoldCycles(ResetHoldCycles)
  ) u_rst_seq (
    .clk  (clk_sys_i),
    .rst_n(rst_sys_ni),
    .hold (state_q == ST_HOLD),
    .go   (go)
  );

  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) state_q <= ST_HOLD;
    else             state_q <= state_d;
  end

  // An exit write takes priority over a timeout match in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HOLD: if (go) state_d = ST_RUN;
      ST_RUN: begin
        if (exit_wr)          state_d = ST_DONE;
        else if (timeout_hit) state_d = ST_TIMEOUT;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      cycle_q     <= '0;
      timeout_q   <= CntWidth'(TimeoutDefault);
      exit_code_q <= '0;
      sys_rst_q   <= 1'b0;
    end else begin
      if ((state_q == ST_RUN) && (state_d == ST_RUN) && (cycle_q != '1)) begin
        cycle_q <= cycle_q + CntWidth'(1);
      end
      if (timeout_wr) timeout_q <= timeout_merged[CntWidth-1:0];
      if (exit_wr) exit_code_q <= device_wdata_i[EXIT_CODE_W-1:0];
      sys_rst_q <= (state_d == ST_RUN);
    end
  end

`ifdef DMS_SIM_CTRL_CONSOLE_EN
  logic [7:0] console_char_q;
  logic       console_valid_q, console_wr;

  assign console_wr = wr_en && (reg_idx == REG_CONSOLE) && device_be_i[0];

  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      console_char_q  <= '0;
      console_valid_q <= 1'b0;
    end else begin
      console_valid_q <= console_wr;
      if (console_wr) console_char_q <= device_wdata_i[7:0];
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_ni && console_wr) $write("%c", device_wdata_i[7:0]);
  end
`endif

  assign console_char_o  = console_char_q;
  assign console_valid_o = console_valid_q;
`endif

  always_comb begin
    read_val = '0;
    unique case (reg_idx)
      REG_EXIT:    read_val = 32'(exit_code_q);
`ifdef DMS_SIM_CTRL_CONSOLE_EN
      REG_CONSOLE: read_val = {24'b0, console_char_q};
`else
      REG_CONSOLE: read_val = '0;
`endif
      REG_CYCLES:  read_val = 32'(cycle_q);
      REG_TIMEOUT: read_val = 32'(timeout_q);
      default:     read_val = '0;
    endcase
  end

  // Every request is answered one cycle later; writes return zero data.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= device_req_i;
      rdata_q  <= (device_req_i && !device_we_i) ? read_val : '0;
    end
  end

  assign device_rvalid_o = rvalid_q;
  assign device_rdata_o  = rdata_q;
  assign sys_rst_no      = sys_rst_q;
  assign done_o          = (state_q == ST_DONE) || (state_q == ST_TIMEOUT);
  assign timeout_o       = (state_q == ST_TIMEOUT);
  assign pass_o          = (state_q == ST_DONE) && (exit_code_q == '0);
  assign exit_code_o     = exit_code_q;
  assign cycle_count_o   = cycle_q;

endmodule

// File: tb/tb_dms_sim_ctrl.sv
// Self-checking bench for dms_sim_ctrl: behavioural model compared every cycle
// plus directed scenarios with literal expectations.
module tb_dms_sim_ctrl;
  import dms_sim_ctrl_pkg::*;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] addr = '0, wdata = '0;

  logic        rvalid, sys_rst_n, done, pass, tmo;
  logic [31:0] rdata, count;
  logic [7:0]  exit_code;
`ifdef DMS_SIM_CTRL_CONSOLE_EN
  logic [7:0]  con_char;
  logic        con_valid;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dms_sim_ctrl #(
    .ResetHoldCycles(HOLD),
    .TimeoutDefault (500),
    .CntWidth       (32)
  ) dut (
    .clk_sys_i      (clk),
    .rst_sys_ni     (rst_n),
    .device_req_i   (req),
    .device_we_i    (we),
    .device_be_i    (be),
    .device_addr_i  (addr),
    .device_wdata_i (wdata),
    .device_rvalid_o(rvalid),
    .device_rdata_o (rdata),
    .sys_rst_no     (sys_rst_n),
    .done_o         (done),
    .pass_o         (pass),
    .timeout_o      (tmo),
    .exit_code_o    (exit_code),
    .cycle_count_o  (count)
`ifdef DMS_SIM_CTRL_CONSOLE_EN
    ,
    .console_char_o (con_char),
    .console_valid_o(con_valid)
`endif
  );

  // Behavioural model: tracks the test lifecycle as plain flags and counters.
  bit          started = 0;
  bit          m_sysrst, m_ended, m_to, m_rvalid;
  int          m_since;
  logic [31:0] m_count, m_treg, m_rdata;
  logic [7:0]  m_exit, m_char;
  bit          m_cvalid;

  always @(posedge clk) begin : model
    logic [31:0] rd;
    logic [1:0]  idx;
    bit          running;
    started = 1;
    idx = addr[3:2];
    if (!rst_n) begin
      m_sysrst = 0; m_ended = 0; m_to = 0; m_rvalid = 0; m_since = 0;
      m_count = 0; m_treg = 500; m_rdata = 0; m_exit = 0; m_char = 0; m_cvalid = 0;
    end else begin
      running = m_sysrst;
      case (idx)
        2'd0:    rd = {24'b0, m_exit};
`ifdef DMS_SIM_CTRL_CONSOLE_EN
        2'd1:    rd = {24'b0, m_char};
`else
        2'd1:    rd = 0;
`endif
        2'd2:    rd = m_count;
        default: rd = m_treg;
      endcase
      m_rvalid = req;
      m_rdata  = (req && !we) ? rd : 32'd0;
      m_cvalid = 0;
      if (running) begin
        if (req && we && idx == 2'd0 && be[0]) begin
          m_exit = wdata[7:0]; m_ended = 1; m_sysrst = 0;
        end else if (m_treg != 0 && m_count == m_treg) begin
          m_ended = 1; m_to = 1; m_sysrst = 0;
        end else if (m_count != 32'hFFFF_FFFF) begin
          m_count = m_count + 1;
        end
        if (req && we && idx == 2'd3) begin
          for (int b = 0; b < 4; b++) if (be[b]) m_treg[8*b +: 8] = wdata[8*b +: 8];
        end
        if (req && we && idx == 2'd1 && be[0]) begin
          m_char = wdata[7:0]; m_cvalid = 1;
        end
      end else if (!m_ended) begin
        m_since++;
        if (m_since == HOLD + 1) m_sysrst = 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic boundExpired(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=bound expired required=event seen", name);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("m_sys_rst", 32'(sys_rst_n), 32'(m_sysrst));
      checkOutput("m_done", 32'(done), 32'(m_ended));
      checkOutput("m_timeout", 32'(tmo), 32'(m_to));
      checkOutput("m_pass", 32'(pass), 32'(m_ended && !m_to && m_exit == 0));
      checkOutput("m_exit", 32'(exit_code), 32'(m_exit));
      checkOutput("m_count", count, m_count);
      checkOutput("m_rvalid", 32'(rvalid), 32'(m_rvalid));
      if (m_rvalid) checkOutput("m_rdata", rdata, m_rdata);
`ifdef DMS_SIM_CTRL_CONSOLE_EN
      checkOutput("m_cvalid", 32'(con_valid), 32'(m_cvalid));
      checkOutput("m_char", 32'(con_char), 32'(m_char));
`endif
    end
  end

  task automatic applyStimulus(input bit w, input logic [1:0] idx,
                               input logic [31:0] d, input logic [3:0] b);
    req = 1; we = w; addr = {28'b0, idx, 2'b00}; wdata = d; be = b;
    @(posedge clk);
    #1;
    req = 0; we = 0; be = '0; wdata = '0;
  endtask

  task automatic restart();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (HOLD + 1) @(posedge clk);
    #1;
    checkOutput("restart_run", 32'(sys_rst_n), 32'd1);
  endtask

  task automatic waitCount(input logic [31:0] target, input int bound, input string name);
    bit hit = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (m_count == target) begin hit = 1; break; end
    end
    if (!hit) boundExpired(name);
  endtask

  initial begin
    bit hit;
    // 1: reset values and hold sequence
    repeat (3) @(negedge clk);
    checkOutput("rst_sys_rst", 32'(sys_rst_n), 32'd0);
    checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_count", count, 32'd0);
    checkOutput("rst_exit", 32'(exit_code), 32'd0);
    rst_n = 1;
    for (int i = 0; i < HOLD; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_low", 32'(sys_rst_n), 32'd0);
    end
    @(posedge clk); #1;
    checkOutput("hold_release", 32'(sys_rst_n), 32'd1);
    checkOutput("run_count0", count, 32'd0);

    // 2: passing exit at cycle 100
    waitCount(32'd100, 200, "wait_count100");
    applyStimulus(1, REG_EXIT, 32'h0, 4'hF);
    checkOutput("exit0_rvalid", 32'(rvalid), 32'd1);
    checkOutput("exit0_done", 32'(done), 32'd1);
    checkOutput("exit0_pass", 32'(pass), 32'd1);
    checkOutput("exit0_count", count, 32'd100);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("exit0_frozen", count, 32'd100);
    applyStimulus(0, REG_CYCLES, 32'h0, 4'h0);
    checkOutput("cycles_read", rdata, 32'd100);

    // 3: byte-enabled TIMEOUT write, failing exit code
    restart();
    applyStimulus(1, REG_TIMEOUT, 32'h1234_5678, 4'b0101);
    applyStimulus(0, REG_TIMEOUT, 32'h0, 4'h0);
    checkOutput("tmo_be_read", rdata, 32'h0034_0178);
    applyStimulus(1, REG_EXIT, 32'h0000_002A, 4'b0001);
    checkOutput("exit2a_done", 32'(done), 32'd1);
    checkOutput("exit2a_pass", 32'(pass), 32'd0);
    checkOutput("exit2a_code", 32'(exit_code), 32'h2A);
    applyStimulus(0, REG_EXIT, 32'h0, 4'h0);
    checkOutput("exit2a_read", rdata, 32'h0000_002A);

    // 4: timeout fires at 20; timeout 0 never fires
    restart();
    applyStimulus(1, REG_TIMEOUT, 32'd20, 4'hF);
    hit = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (m_to) begin hit = 1; break; end
    end
    if (!hit) boundExpired("wait_timeout20");
    checkOutput("to20_timeout", 32'(tmo), 32'd1);
    checkOutput("to20_count", count, 32'd20);
    checkOutput("to20_sys_rst", 32'(sys_rst_n), 32'd0);
    checkOutput("to20_pass", 32'(pass), 32'd0);
    checkOutput("to20_done", 32'(done), 32'd1);
    restart();
    applyStimulus(1, REG_TIMEOUT, 32'd0, 4'hF);
    repeat (600) @(posedge clk);
    #1;
    checkOutput("to0_timeout", 32'(tmo), 32'd0);
    checkOutput("to0_done", 32'(done), 32'd0);
    checkOutput("to0_count", count, 32'd601);
    checkOutput("to0_sys_rst", 32'(sys_rst_n), 32'd1);

    // 5: exit in the timeout-match cycle, then writes ignored
    restart();
    applyStimulus(1, REG_TIMEOUT, 32'd30, 4'hF);
    waitCount(32'd30, 60, "wait_count30");
    applyStimulus(1, REG_EXIT, 32'h0000_0005, 4'hF);
    checkOutput("race_done", 32'(done), 32'd1);
    checkOutput("race_timeout", 32'(tmo), 32'd0);
    checkOutput("race_exit", 32'(exit_code), 32'h05);
    checkOutput("race_count", count, 32'd30);
    applyStimulus(1, REG_EXIT, 32'h0000_0077, 4'hF);
    checkOutput("late_wr_rvalid", 32'(rvalid), 32'd1);
    checkOutput("late_wr_rdata", rdata, 32'd0);
    checkOutput("late_wr_exit", 32'(exit_code), 32'h05);
    applyStimulus(0, REG_EXIT, 32'h0, 4'h0);
    checkOutput("late_rd", rdata, 32'h0000_0005);

    // 6: one-cycle reset mid-run, then CONSOLE access
    restart();
    repeat (10) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    checkOutput("midrst_sys_rst", 32'(sys_rst_n), 32'd0);
    checkOutput("midrst_count", count, 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    for (int i = 0; i < HOLD; i++) begin
      @(posedge clk); #1;
      checkOutput("rehold_low", 32'(sys_rst_n), 32'd0);
    end
    @(posedge clk); #1;
    checkOutput("rehold_release", 32'(sys_rst_n), 32'd1);
    applyStimulus(1, REG_CONSOLE, 32'h0000_0041, 4'b0001);
`ifdef DMS_SIM_CTRL_CONSOLE_EN
    checkOutput("con_char", 32'(con_char), 32'h41);
    checkOutput("con_valid", 32'(con_valid), 32'd1);
    applyStimulus(0, REG_CONSOLE, 32'h0, 4'h0);
    checkOutput("con_valid_pulse", 32'(con_valid), 32'd0);
    checkOutput("con_read", rdata, 32'h0000_0041);
`else
    applyStimulus(0, REG_CONSOLE, 32'h0, 4'h0);
    checkOutput("con_read", rdata, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
